// File: rtl/acc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : acc_pkg                                                  |
// | Description : Shared definitions for the accelerator APB master: FSM   |
// |               state encoding, address width default and accelerator    |
// |               control register constants.                              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package acc_pkg;

  // Address width of the accelerator APB slave
  localparam int ACC_APB_ADDR_WIDTH = 13;

  // Accelerator control register and the values written to start/stop it
  localparam logic [ACC_APB_ADDR_WIDTH-1:0] ACC_CTRL_ADDR = '0;
  localparam logic [31:0] ACC_EN_VALUE  = 32'd1;
  localparam logic [31:0] ACC_END_VALUE = 32'd0;

  // APB initiator transfer phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/acc_apb_timeout.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : acc_apb_timeout                                          |
// | Description : Counts ACCESS-phase wait cycles and flags the cycle on   |
// |               which the wait budget is exhausted.                      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module acc_apb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic HCLK,
  input  logic rst,
  input  logic clear,       // entering ACCESS: restart the count
  input  logic wait_cycle,  // ACCESS cycle with PREADY low
  output logic limit_hit    // this wait cycle is the last one allowed
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_d, count_q;

  // The count holds the number of wait cycles already spent, so the
  // TIMEOUT_CYCLES-th wait cycle is the one that sees LIMIT.
  assign limit_hit = (count_q == LIMIT);

  // Next count: clear has priority, then one step per wait cycle
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wait_cycle) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge HCLK) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/acc_apb_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : acc_apb_master                                           |
// | Description : Single-outstanding APB initiator driving the accelerator |
// |               register slave from a valid/ready command interface.     |
// |               Optional ACCESS wait timeout enabled by defining         |
// |               ACC_APB_MASTER_TIMEOUT_EN.                               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module acc_apb_master
  import acc_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = ACC_APB_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      rst,
  // command side
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]               cmd_wdata,
  // response side
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  // APB initiator
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_state_e                state_d, state_q;
  logic                      psel_d, psel_q;
  logic                      penable_d, penable_q;
  logic                      pwrite_d, pwrite_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_d, paddr_q;
  logic [31:0]               pwdata_d, pwdata_q;
  logic                      rsp_valid_d, rsp_valid_q;
  logic [31:0]               rsp_rdata_d, rsp_rdata_q;
  logic                      rsp_err_d, rsp_err_q;
  logic                      timeout_hit;

`ifdef ACC_APB_MASTER_TIMEOUT_EN
  logic rsp_timeout_d, rsp_timeout_q;

  // Wait-cycle budget for the ACCESS phase
  acc_apb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .HCLK       (HCLK),
    .rst        (rst),
    .clear      (state_q == ST_SETUP),
    .wait_cycle ((state_q == ST_ACCESS) && !PREADY),
    .limit_hit  (timeout_hit)
  );

  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;

  // ACCESS waits for PREADY indefinitely
  assign timeout_hit        = 1'b0;
  assign rsp_timeout        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Commands are only taken between transfers
  assign cmd_ready = (state_q == ST_IDLE);

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and next-output decode; APB outputs are computed one
  // cycle ahead so every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef ACC_APB_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY || timeout_hit) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          rsp_valid_d = 1'b1;
          if (PREADY) begin
            // A write has no read data to return
            rsp_rdata_d = pwrite_q ? 32'd0 : PRDATA;
            rsp_err_d   = PSLVERR;
`ifdef ACC_APB_MASTER_TIMEOUT_EN
            rsp_timeout_d = 1'b0;
`endif
          end else begin
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b1;
`ifdef ACC_APB_MASTER_TIMEOUT_EN
            rsp_timeout_d = 1'b1;
`endif
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight
  always_ff @(posedge HCLK) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef ACC_APB_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ACC_APB_MASTER_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_apb_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_acc_apb_master                                        |
// | Description : Self-checking bench for acc_apb_master with a reactive   |
// |               APB slave and a transaction-level reference model.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_acc_apb_master;
  import acc_pkg::*;

  localparam int AW = 13;
  localparam int TO = 8;

  logic          HCLK = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;
  logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  always #5 HCLK = ~HCLK;

  acc_apb_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Protocol rules that hold on every cycle
  always @(negedge HCLK) begin
    if (mon_en) begin
      n_tests++;
      if (PENABLE === 1'b1 && PSEL !== 1'b1) begin
        n_fail++;
        $display("FAIL mon_penable_without_psel: PSEL=%b PENABLE=%b, required PSEL=1", PSEL, PENABLE);
      end else if (PSEL !== 1'b1 && (PADDR !== '0 || PWDATA !== '0)) begin
        n_fail++;
        $display("FAIL mon_idle_bus: PADDR=%h PWDATA=%h, required 0 when PSEL=0", PADDR, PWDATA);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  // Offers one command and plays an APB slave that inserts 'waits' wait
  // cycles; reports what the DUT did, checks are made by the callers.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                         input int waits, input logic [31:0] rd, input logic err_rdy,
                         input logic err_wait, input int max_k,
                         output int lat, output int psel_k, output int pen_k,
                         output bit held, output bit stable, output logic [31:0] got_rd,
                         output logic got_err, output logic got_to);
    int acc;
    int guard;
    lat = -1; psel_k = -1; pen_k = -1; held = 1'b1; stable = 1'b1;
    got_rd = 'x; got_err = 1'bx; got_to = 1'bx; acc = 0; guard = 0;
    while (cmd_ready !== 1'b1 && guard < 10) begin
      next_cycle();
      guard++;
    end
    if (cmd_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b, required 1 within 10 cycles", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    for (int k = 1; k <= max_k; k++) begin
      next_cycle();
      if (k == 1) begin
        cmd_valid = 1'b0; cmd_write = 1'($urandom);
        cmd_addr = AW'($urandom); cmd_wdata = $urandom;
      end
      if (rsp_valid === 1'b1) begin
        lat = k; got_rd = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
        break;
      end
      if (PSEL === 1'b1 && psel_k < 0) psel_k = k;
      if (PENABLE === 1'b1 && pen_k < 0) pen_k = k;
      if (PSEL !== 1'b1) held = 1'b0;
      else if (PADDR !== addr || PWDATA !== wd || PWRITE !== wr) stable = 1'b0;
      if (PENABLE === 1'b1) begin
        acc++;
        PREADY  = (acc > waits);
        PSLVERR = PREADY ? err_rdy : err_wait;
        PRDATA  = PREADY ? rd : $urandom;
      end else begin
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) next_cycle();
    n_tests++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: PSEL,PENABLE,PWRITE,rsp_valid,rsp_err,rsp_timeout=%b, required 000000",
               {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout});
    end
    n_tests++;
    if (PADDR !== '0 || PWDATA !== '0 || rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: PADDR=%h PWDATA=%h rsp_rdata=%h, required all 0", PADDR, PWDATA, rsp_rdata);
    end
    rst = 1'b0;
    next_cycle();
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_zero_wait_write();
    int lat, pk, ek; bit held, stable; logic [31:0] rd; logic er, to;
    run_txn(1'b1, ACC_CTRL_ADDR, ACC_EN_VALUE, 0, 32'hA5A5_5A5A, 1'b0, 1'b0, 20,
            lat, pk, ek, held, stable, rd, er, to);
    n_tests++; if (pk !== 1) begin n_fail++; $display("FAIL zw_psel_rise: cycle %0d, required 1", pk); end
    n_tests++; if (ek !== 2) begin n_fail++; $display("FAIL zw_penable_rise: cycle %0d, required 2", ek); end
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL zw_rsp_latency: cycle %0d, required 3", lat); end
    n_tests++; if (er !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL zw_rsp: err=%b rdata=%h, required 0/0", er, rd); end
    n_tests++; if (!stable) begin n_fail++; $display("FAIL zw_bus_stable: got 0, required 1"); end
  endtask

  task automatic test_waited_read();
    int lat, pk, ek; bit held, stable; logic [31:0] rd; logic er, to;
    run_txn(1'b0, 13'h010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 20,
            lat, pk, ek, held, stable, rd, er, to);
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL wr_rsp_latency: cycle %0d, required 6", lat); end
    n_tests++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rdata: got %h, required deadbeef", rd); end
    n_tests++; if (!stable || !held) begin n_fail++; $display("FAIL wr_paddr_stable: stable=%b held=%b, required 1/1", stable, held); end
    next_cycle();
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wr_rsp_hold: rsp_valid=%b rsp_rdata=%h, required 0/deadbeef", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_slave_error();
    int lat, pk, ek; bit held, stable; logic [31:0] rd; logic er, to;
    run_txn(1'b0, 13'h020, 32'h0, 0, 32'h1111_2222, 1'b1, 1'b0, 20,
            lat, pk, ek, held, stable, rd, er, to);
    n_tests++; if (er !== 1'b1 || lat !== 3) begin n_fail++; $display("FAIL se_err_at_ready: err=%b lat=%0d, required 1/3", er, lat); end
    run_txn(1'b0, 13'h020, 32'h0, 2, 32'h3333_4444, 1'b0, 1'b1, 20,
            lat, pk, ek, held, stable, rd, er, to);
    n_tests++; if (er !== 1'b0 || lat !== 5) begin n_fail++; $display("FAIL se_err_during_wait: err=%b lat=%0d, required 0/5", er, lat); end
    n_tests++; if (rd !== 32'h3333_4444) begin n_fail++; $display("FAIL se_rdata: got %h, required 33334444", rd); end
  endtask

  task automatic test_timeout();
    int lat, pk, ek; bit held, stable; logic [31:0] rd; logic er, to;
`ifdef ACC_APB_MASTER_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      run_txn(1'b0, 13'h040, 32'h0, 1000, 32'h5555_6666, 1'b0, 1'b0, 30,
              lat, pk, ek, held, stable, rd, er, to);
      n_tests++; if (lat !== 2 + TO) begin n_fail++; $display("FAIL to_latency: cycle %0d, required %0d", lat, 2 + TO); end
      n_tests++;
      if (to !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin
        n_fail++;
        $display("FAIL to_rsp: timeout=%b err=%b rdata=%h, required 1/1/0", to, er, rd);
      end
      next_cycle();
      n_tests++; if (PSEL !== 1'b0) begin n_fail++; $display("FAIL to_psel_after: got %b, required 0", PSEL); end
    end
    // Ready arrives on the last allowed wait cycle: normal completion
    run_txn(1'b0, 13'h044, 32'h0, TO - 1, 32'h7777_8888, 1'b0, 1'b0, 30,
            lat, pk, ek, held, stable, rd, er, to);
    n_tests++;
    if (lat !== 2 + TO || to !== 1'b0 || er !== 1'b0 || rd !== 32'h7777_8888) begin
      n_fail++;
      $display("FAIL to_limit_ready: lat=%0d timeout=%b err=%b rdata=%h, required %0d/0/0/77778888",
               lat, to, er, rd, 2 + TO);
    end
`else
    run_txn(1'b0, 13'h040, 32'h0, 1000, 32'h5555_6666, 1'b0, 1'b0, 40,
            lat, pk, ek, held, stable, rd, er, to);
    n_tests++; if (lat !== -1) begin n_fail++; $display("FAIL nto_no_rsp: rsp at cycle %0d, required none", lat); end
    n_tests++; if (!held) begin n_fail++; $display("FAIL nto_psel_held: got 0, required 1"); end
    n_tests++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL nto_rsp_timeout: got %b, required 0", rsp_timeout); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    n_tests++; if (PSEL !== 1'b0) begin n_fail++; $display("FAIL nto_abort: PSEL=%b, required 0", PSEL); end
`endif
  endtask

  task automatic test_reset_mid_transfer();
    bit seen_rsp;
    seen_rsp = 1'b0;
    next_cycle();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h030; cmd_wdata = 32'h0;
    PREADY = 1'b0; PSLVERR = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      if (k == 1) cmd_valid = 1'b0;
      if (rsp_valid === 1'b1) seen_rsp = 1'b1;
      if (k == 3) begin
        n_tests++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
          n_fail++;
          $display("FAIL rmt_in_access: PSEL=%b PENABLE=%b, required 1/1", PSEL, PENABLE);
        end
        rst = 1'b1;
      end
      if (k == 4) begin
        n_tests++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rmt_after_reset: PSEL=%b PENABLE=%b rsp_valid=%b, required 0/0/0", PSEL, PENABLE, rsp_valid);
        end
        rst = 1'b0;
        PREADY = 1'b1;
      end
      if (k == 5) begin
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmt_cmd_ready: got %b, required 1", cmd_ready); end
      end
    end
    PREADY = 1'b0;
    n_tests++; if (seen_rsp) begin n_fail++; $display("FAIL rmt_no_rsp: rsp_valid seen, required none"); end
  endtask

  task automatic test_back_to_back();
    int acc_k[$]; int rsp_k[$]; logic [11:0] psel_bits; logic [31:0] rd_q[$];
    bit switched; int guard;
    switched = 1'b0; psel_bits = '0; guard = 0;
    while (cmd_ready !== 1'b1 && guard < 10) begin next_cycle(); guard++; end
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h1234_5678;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h100; cmd_wdata = 32'hCAFE_0001;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) next_cycle();
      if (acc_k.size() == 1 && !switched) begin
        switched = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h104; cmd_wdata = 32'h0;
      end
      if (acc_k.size() == 2) cmd_valid = 1'b0;
      psel_bits[k] = PSEL;
      if (rsp_valid === 1'b1) begin rsp_k.push_back(k); rd_q.push_back(rsp_rdata); end
      if (k == 5) begin
        n_tests++;
        if (PADDR !== 13'h104 || PWRITE !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_second_cmd: PADDR=%h PWRITE=%b, required 104/0", PADDR, PWRITE);
        end
      end
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) acc_k.push_back(k);
    end
    PREADY = 1'b0;
    n_tests++;
    if (acc_k.size() != 2 || acc_k[0] != 0 || acc_k[1] != 4) begin
      n_fail++;
      $display("FAIL b2b_accept: %0d accepts, second at %0d, required 2 with second at 4",
               acc_k.size(), (acc_k.size() > 1) ? acc_k[1] : -1);
    end
    n_tests++;
    if (rsp_k.size() != 2 || rsp_k[0] != 3 || rsp_k[1] != 7) begin
      n_fail++;
      $display("FAIL b2b_rsp: %0d responses, first at %0d, required 2 at 3 and 7",
               rsp_k.size(), (rsp_k.size() > 0) ? rsp_k[0] : -1);
    end
    n_tests++;
    if (psel_bits !== 12'h066) begin n_fail++; $display("FAIL b2b_psel_pattern: got %b, required 000001100110", psel_bits); end
    n_tests++;
    if (rd_q.size() != 2 || rd_q[0] !== 32'd0 || rd_q[1] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL b2b_rdata: got %0d responses, required write 0 then 12345678", rd_q.size());
    end
  endtask

  // Random transfers against the transaction-level model:
  // latency = 3 + waits, rdata = read ? PRDATA : 0, err = PSLVERR at ready.
  task automatic test_random();
    int lat, pk, ek; bit held, stable; logic [31:0] rd; logic er, to;
    logic wr; logic [AW-1:0] addr; logic [31:0] wd, prd; int waits; logic e_rdy, e_wait;
    for (int t = 0; t < 16; t++) begin
      wr = 1'($urandom); addr = AW'($urandom); wd = $urandom; prd = $urandom;
      waits = int'($urandom_range(0, 5)); e_rdy = 1'($urandom); e_wait = 1'($urandom);
      run_txn(wr, addr, wd, waits, prd, e_rdy, e_wait, 20, lat, pk, ek, held, stable, rd, er, to);
      n_tests++;
      if (lat !== 3 + waits) begin n_fail++; $display("FAIL rnd_latency[%0d]: cycle %0d, required %0d", t, lat, 3 + waits); end
      n_tests++;
      if (rd !== (wr ? 32'd0 : prd)) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h, required %h", t, rd, wr ? 32'd0 : prd); end
      n_tests++;
      if (er !== e_rdy || to !== 1'b0) begin n_fail++; $display("FAIL rnd_err[%0d]: err=%b timeout=%b, required %b/0", t, er, to, e_rdy); end
      n_tests++;
      if (!stable || !held) begin n_fail++; $display("FAIL rnd_bus[%0d]: stable=%b held=%b, required 1/1", t, stable, held); end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_zero_wait_write();
    test_waited_read();
    test_slave_error();
    test_timeout();
    test_reset_mid_transfer();
    test_back_to_back();
    test_random();
    repeat (2) next_cycle();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
